// File: rtl/i2c_tx_arbiter.sv
// rtl/i2c_tx_arbiter.sv - round-robin sequencer sharing one byte-write I2C master; NACK retry enabled by I2C_ARB_RETRY_EN
module i2c_tx_arbiter #(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = 64,
   parameter int MAX_RETRY   = 2
) (
   input  logic              i2c_clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [7*NREQ-1:0] req_addr,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   nack,
   output logic              timeout,
   output logic              busy,
   output logic              mst_start,
   output logic [6:0]        mst_addr,
   output logic [7:0]        mst_data,
   input  logic              mst_busy,
   input  logic              mst_done,
   input  logic              mst_nack
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW   = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [NREQ-1:0] ONE_HOT0   = NREQ'(1);

   // Parameter sanity: refuse to elaborate outside the supported range
   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 4 || MAX_RETRY < 0) begin : g_bad_param
      $error("i2c_tx_arbiter: unsupported parameter set");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state, state_nx;
   logic [IDXW-1:0]   last, last_nx;
   logic [IDXW-1:0]   wsel, wsel_nx;
   logic              result, result_nx;
   logic [TW-1:0]     timer, timer_nx;
   logic [NREQ-1:0]   gnt_nx, done_nx, nack_nx;
   logic              timeout_nx, start_nx;
   logic [6:0]        addr_nx;
   logic [7:0]        data_nx;
   logic              win_found;
   logic [IDXW-1:0]   win_idx;
   int                cand;
   logic [6:0]        addr_arr [NREQ];
   logic [7:0]        data_arr [NREQ];

`ifdef I2C_ARB_RETRY_EN
   localparam int RW = $clog2(MAX_RETRY + 2);
   logic [RW-1:0]     retry_cnt, retry_nx;
`endif

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[7*g +: 7];
      assign data_arr[g] = req_data[8*g +: 8];
   end

   assign busy = (state != IDLE);

   // Round-robin search: first pending requester after the last one served
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!win_found && req[IDXW'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDXW'(cand);
         end
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_nx   = state;
      gnt_nx     = gnt;
      done_nx    = '0;
      nack_nx    = '0;
      timeout_nx = 1'b0;
      start_nx   = 1'b0;
      addr_nx    = mst_addr;
      data_nx    = mst_data;
      last_nx    = last;
      wsel_nx    = wsel;
      result_nx  = result;
      timer_nx   = timer;
`ifdef I2C_ARB_RETRY_EN
      retry_nx   = retry_cnt;
`endif
      case (state)
         IDLE: begin
            if (win_found) begin
               addr_nx  = addr_arr[win_idx];
               data_nx  = data_arr[win_idx];
               gnt_nx   = ONE_HOT0 << win_idx;
               wsel_nx  = win_idx;
`ifdef I2C_ARB_RETRY_EN
               retry_nx = '0;
`endif
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            if (!mst_busy) begin
               start_nx = 1'b1;
               timer_nx = '0;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (timer != TIMER_LAST) timer_nx = timer + 1'b1;
            // A completion in the expiry cycle takes precedence over the timeout
            if (mst_done) begin
               if (!mst_nack) begin
                  result_nx = 1'b0;
                  state_nx  = RESP;
               end else begin
`ifdef I2C_ARB_RETRY_EN
                  if (retry_cnt < RW'(MAX_RETRY)) begin
                     retry_nx = retry_cnt + 1'b1;
                     state_nx = ISSUE;
                  end else begin
                     result_nx = 1'b1;
                     state_nx  = RESP;
                  end
`else
                  result_nx = 1'b1;
                  state_nx  = RESP;
`endif
               end
            end else if (timer == TIMER_LAST) begin
               result_nx  = 1'b1;
               timeout_nx = 1'b1;
               state_nx   = RESP;
            end
         end
         RESP: begin
            done_nx  = ONE_HOT0 << wsel;
            nack_nx  = result ? (ONE_HOT0 << wsel) : '0;
            gnt_nx   = '0;
            last_nx  = wsel;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i2c_clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Registered outputs and per-transaction context
   always_ff @(posedge i2c_clk) begin
      if (!reset) begin
         gnt       <= '0;
         done      <= '0;
         nack      <= '0;
         timeout   <= 1'b0;
         mst_start <= 1'b0;
         mst_addr  <= '0;
         mst_data  <= '0;
         last      <= IDXW'(NREQ - 1);
         wsel      <= '0;
         result    <= 1'b0;
         timer     <= '0;
      end else begin
         gnt       <= gnt_nx;
         done      <= done_nx;
         nack      <= nack_nx;
         timeout   <= timeout_nx;
         mst_start <= start_nx;
         mst_addr  <= addr_nx;
         mst_data  <= data_nx;
         last      <= last_nx;
         wsel      <= wsel_nx;
         result    <= result_nx;
         timer     <= timer_nx;
      end
   end

`ifdef I2C_ARB_RETRY_EN
   // NACK retry counter, cleared on every new grant
   always_ff @(posedge i2c_clk) begin
      if (!reset) retry_cnt <= '0;
      else        retry_cnt <= retry_nx;
   end
`endif

endmodule

// File: tb/tb_i2c_tx_arbiter.sv
// tb/tb_i2c_tx_arbiter.sv - self-checking bench for i2c_tx_arbiter
module tb_i2c_tx_arbiter;

   localparam int NREQ        = 4;
   localparam int TIMEOUT_CYC = 64;
   localparam int MAX_RETRY   = 2;
`ifdef I2C_ARB_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
`else
   localparam bit RETRY_ON = 1'b0;
`endif
   localparam int NACK_STARTS = RETRY_ON ? MAX_RETRY + 1 : 1;
   localparam logic [7*NREQ-1:0] ADDR_INIT = {7'h13, 7'h3F, 7'h11, 7'h10};
   localparam logic [8*NREQ-1:0] DATA_INIT = {8'hA3, 8'h41, 8'hA1, 8'hA0};

   logic              i2c_clk;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [7*NREQ-1:0] req_addr;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   gnt, done, nack;
   logic              timeout, busy, mst_start;
   logic [6:0]        mst_addr;
   logic [7:0]        mst_data;
   logic              mst_busy, mst_done, mst_nack;

   i2c_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) dut (
      .i2c_clk(i2c_clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
      .gnt(gnt), .done(done), .nack(nack), .timeout(timeout), .busy(busy),
      .mst_start(mst_start), .mst_addr(mst_addr), .mst_data(mst_data),
      .mst_busy(mst_busy), .mst_done(mst_done), .mst_nack(mst_nack)
   );

   initial begin
      i2c_clk = 1'b0;
      forever #5 i2c_clk = ~i2c_clk;
   end

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
      end
   endtask

   // ---------------- reference model ----------------
   logic [NREQ-1:0] exp_gnt, exp_done, exp_nack;
   logic            exp_timeout, exp_busy, exp_start;
   logic [6:0]      exp_addr;
   logic [7:0]      exp_data;
   int              m_last;

   function automatic int pick(input logic [NREQ-1:0] rq, input int after);
      for (int k = 1; k <= NREQ; k++) begin
         if (rq[(after + k) % NREQ]) return (after + k) % NREQ;
      end
      return 0;
   endfunction

   task automatic step(output bit r);
      @(posedge i2c_clk);
      exp_start   = 1'b0;
      exp_done    = '0;
      exp_nack    = '0;
      exp_timeout = 1'b0;
      r = !reset;
      if (r) begin
         exp_gnt  = '0;
         exp_busy = 1'b0;
         exp_addr = '0;
         exp_data = '0;
         m_last   = NREQ - 1;
      end
   endtask

   initial begin : model
      bit r, res, fin;
      int w, k, tries;
      exp_gnt = '0; exp_done = '0; exp_nack = '0; exp_timeout = 1'b0;
      exp_busy = 1'b0; exp_start = 1'b0; exp_addr = '0; exp_data = '0;
      m_last = NREQ - 1;
      forever begin
         step(r);
         if (r || req == '0) continue;
         w        = pick(req, m_last);
         exp_gnt  = NREQ'(1) << w;
         exp_busy = 1'b1;
         exp_addr = req_addr[7*w +: 7];
         exp_data = req_data[8*w +: 8];
         tries = 0; fin = 1'b0; res = 1'b0;
         while (!fin && !r) begin
            step(r);
            while (!r && mst_busy) step(r);
            if (r) break;
            exp_start = 1'b1;
            k = 0;
            while (1) begin
               step(r);
               if (r) break;
               k++;
               if (mst_done) begin
                  if (mst_nack && RETRY_ON && tries < MAX_RETRY) begin
                     tries++;
                     break;
                  end
                  res = mst_nack; fin = 1'b1;
                  break;
               end
               if (k == TIMEOUT_CYC) begin
                  res = 1'b1; exp_timeout = 1'b1; fin = 1'b1;
                  break;
               end
            end
         end
         if (r) continue;
         step(r);
         if (r) continue;
         exp_done = NREQ'(1) << w;
         exp_nack = res ? (NREQ'(1) << w) : '0;
         exp_gnt  = '0;
         exp_busy = 1'b0;
         m_last   = w;
      end
   end

   // ---------------- master responder ----------------
   int slv_lat    = 2;
   bit slv_nack   = 1'b0;
   bit slv_silent = 1'b0;

   initial begin : master
      int cnt;
      cnt = 0;
      mst_done = 1'b0;
      mst_nack = 1'b0;
      forever begin
         @(negedge i2c_clk);
         mst_done = 1'b0;
         mst_nack = 1'b0;
         if (!reset) cnt = 0;
         else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mst_done = 1'b1;
               mst_nack = slv_nack;
            end
         end else if (mst_start && !slv_silent) cnt = slv_lat;
      end
   end

   // ---------------- compare and record ----------------
   int cyc_n = 0;
   int order[$];
   logic [NREQ-1:0] prev_gnt = '0;
   int n_start = 0, n_done = 0, n_tmo = 0;
   int gnt_cyc = 0, start_cyc = 0, tmo_cyc = 0, done_cyc = 0;
   logic [6:0] start_addr = '0;
   logic [7:0] start_data = '0;
   logic [NREQ-1:0] done_vec = '0, nack_vec = '0;

   initial begin : mon
      forever begin
         @(negedge i2c_clk);
         cyc_n++;
         if (chk_en) begin
            check($sformatf("c%0d gnt", cyc_n), 64'(gnt), 64'(exp_gnt));
            check($sformatf("c%0d done", cyc_n), 64'(done), 64'(exp_done));
            check($sformatf("c%0d nack", cyc_n), 64'(nack), 64'(exp_nack));
            check($sformatf("c%0d timeout", cyc_n), 64'(timeout), 64'(exp_timeout));
            check($sformatf("c%0d busy", cyc_n), 64'(busy), 64'(exp_busy));
            check($sformatf("c%0d mst_start", cyc_n), 64'(mst_start), 64'(exp_start));
            check($sformatf("c%0d mst_addr", cyc_n), 64'(mst_addr), 64'(exp_addr));
            check($sformatf("c%0d mst_data", cyc_n), 64'(mst_data), 64'(exp_data));
         end
         if (gnt != '0 && prev_gnt == '0) begin
            for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
            gnt_cyc = cyc_n;
         end
         prev_gnt = gnt;
         if (mst_start) begin
            n_start++; start_cyc = cyc_n; start_addr = mst_addr; start_data = mst_data;
         end
         if (timeout) begin
            n_tmo++; tmo_cyc = cyc_n;
         end
         if (done != '0) begin
            n_done++; done_cyc = cyc_n; done_vec = done; nack_vec = nack;
            req = req & ~done;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(negedge i2c_clk);
      #1;
   endtask

   task automatic wait_dones(input int target, input int budget, input string nm);
      int c;
      c = 0;
      while (n_done < target && c < budget) begin
         cyc();
         c++;
      end
      check(nm, 64'(n_done), 64'(target));
   endtask

   initial begin : stim
      int s0, d0, t0, c;
      int exp_ord[4];
      reset = 1'b0; req = '0; mst_busy = 1'b0;
      req_addr = ADDR_INIT; req_data = DATA_INIT;
      repeat (3) cyc();
      chk_en = 1'b1;
      check("t0_gnt", 64'(gnt), 64'(0));
      check("t0_busy", 64'(busy), 64'(0));
      check("t0_start", 64'(mst_start), 64'(0));
      check("t0_addr", 64'(mst_addr), 64'(0));
      reset = 1'b1;
      cyc();

      // T1: single request, data changes after latch ignored
      s0 = n_start; d0 = n_done; order.delete();
      slv_lat = 3; slv_nack = 1'b0; slv_silent = 1'b0;
      req[2] = 1'b1;
      cyc();
      check("t1_gnt_next", 64'(gnt), 64'(4'b0100));
      req_addr[14 +: 7] = 7'h00;
      req_data[16 +: 8] = 8'h00;
      wait_dones(d0 + 1, 50, "t1_done_cnt");
      req_addr = ADDR_INIT; req_data = DATA_INIT;
      check("t1_starts", 64'(n_start - s0), 64'(1));
      check("t1_addr", 64'(start_addr), 64'(7'h3F));
      check("t1_data", 64'(start_data), 64'(8'h41));
      check("t1_done_vec", 64'(done_vec), 64'(4'b0100));
      check("t1_nack_vec", 64'(nack_vec), 64'(0));

      // T2: simultaneous 0,1,3 after reset, then 0 re-requests
      reset = 1'b0; cyc(); cyc(); reset = 1'b1;
      d0 = n_done; order.delete();
      req = 4'b1011;
      c = 0;
      while (!gnt[1] && c < 100) begin cyc(); c++; end
      check("t2_gnt1_seen", 64'(gnt[1]), 64'(1));
      req[0] = 1'b1;
      wait_dones(d0 + 4, 200, "t2_done_cnt");
      exp_ord = '{0, 1, 3, 0};
      check("t2_order_len", 64'(order.size()), 64'(4));
      for (int i = 0; i < 4; i++)
         check($sformatf("t2_order%0d", i), 64'((i < order.size()) ? order[i] : -1), 64'(exp_ord[i]));

      // T3: master busy for 10 cycles after grant
      s0 = n_start; d0 = n_done; order.delete();
      slv_lat = 2; mst_busy = 1'b1; req[1] = 1'b1;
      c = 0;
      while (gnt == '0 && c < 10) begin cyc(); c++; end
      repeat (10) cyc();
      mst_busy = 1'b0;
      wait_dones(d0 + 1, 50, "t3_done_cnt");
      check("t3_starts", 64'(n_start - s0), 64'(1));
      check("t3_start_delay", 64'(start_cyc - gnt_cyc), 64'(11));
      check("t3_winner", 64'((order.size() > 0) ? order[0] : -1), 64'(1));

      // T4: master always NACKs
      s0 = n_start; d0 = n_done; t0 = n_tmo;
      slv_nack = 1'b1; req[2] = 1'b1;
      wait_dones(d0 + 1, 100, "t4_done_cnt");
      slv_nack = 1'b0;
      check("t4_starts", 64'(n_start - s0), 64'(NACK_STARTS));
      check("t4_done_vec", 64'(done_vec), 64'(4'b0100));
      check("t4_nack_vec", 64'(nack_vec), 64'(4'b0100));
      check("t4_no_timeout", 64'(n_tmo - t0), 64'(0));

      // T5: master never completes
      s0 = n_start; d0 = n_done; t0 = n_tmo;
      slv_silent = 1'b1; req[3] = 1'b1;
      wait_dones(d0 + 1, 150, "t5_done_cnt");
      slv_silent = 1'b0;
      check("t5_timeouts", 64'(n_tmo - t0), 64'(1));
      check("t5_tmo_delay", 64'(tmo_cyc - start_cyc), 64'(64));
      check("t5_done_delay", 64'(done_cyc - start_cyc), 64'(65));
      check("t5_nack_vec", 64'(nack_vec), 64'(4'b1000));
      check("t5_starts", 64'(n_start - s0), 64'(1));

      // T6: completion lands exactly on the expiry cycle
      d0 = n_done; t0 = n_tmo;
      slv_lat = 63; req[0] = 1'b1;
      wait_dones(d0 + 1, 150, "t6_done_cnt");
      slv_lat = 2;
      check("t6_timeouts", 64'(n_tmo - t0), 64'(0));
      check("t6_done_vec", 64'(done_vec), 64'(4'b0001));
      check("t6_nack_vec", 64'(nack_vec), 64'(0));
      check("t6_done_delay", 64'(done_cyc - start_cyc), 64'(65));

      // T7: reset in the middle of WAIT
      s0 = n_start; d0 = n_done;
      slv_silent = 1'b1; req[1] = 1'b1;
      c = 0;
      while (n_start == s0 && c < 20) begin cyc(); c++; end
      repeat (3) cyc();
      req[3] = 1'b1;
      reset = 1'b0;
      cyc();
      check("t7_gnt", 64'(gnt), 64'(0));
      check("t7_done", 64'(done), 64'(0));
      check("t7_nack", 64'(nack), 64'(0));
      check("t7_timeout", 64'(timeout), 64'(0));
      check("t7_busy", 64'(busy), 64'(0));
      check("t7_start", 64'(mst_start), 64'(0));
      check("t7_addr", 64'(mst_addr), 64'(0));
      check("t7_data", 64'(mst_data), 64'(0));
      check("t7_no_done", 64'(n_done), 64'(d0));
      slv_silent = 1'b0; order.delete();
      reset = 1'b1;
      wait_dones(d0 + 2, 100, "t7_done_cnt");
      check("t7_first", 64'((order.size() > 0) ? order[0] : -1), 64'(1));
      check("t7_second", 64'((order.size() > 1) ? order[1] : -1), 64'(3));

      repeat (3) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got no finish by 30000 cycles, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/i2c_tx_arbiter.md
# i2c_tx_arbiter

Round-robin arbiter and transaction sequencer that shares one byte-write I2C master between NREQ requesters. It accepts per-requester write requests (7-bit target address plus one data byte) and issues them to the master one at a time. It tracks completion, ACK/NACK and timeout, and returns a per-requester completion pulse with status. It sits between the system-side command sources and the I2C transmit master, in the `i2c_clk` domain.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYC`, 64, max cycles in WAIT before abort (≥4)
- `MAX_RETRY`, 2, NACK retries per transaction (used only with retry compiled in)

- `i2c_clk` in 1, single clock, all logic on rising edge
- `reset` in 1, synchronous, active-low
- `req` in NREQ, request per requester; held high until its `done`
- `req_addr` in 7*NREQ, requester i address at [7i+6:7i]
- `req_data` in 8*NREQ, requester i byte at [8i+7:8i]
- `gnt` out NREQ, one-hot; high while requester is being served
- `done` out NREQ, one-cycle completion pulse
- `nack` out NREQ, final status, valid only with `done` (1 = NACK or timeout)
- `timeout` out 1, one-cycle pulse when a transaction is aborted by timeout
- `busy` out 1, high in any state except IDLE
- `mst_start` out 1, one-cycle command pulse to master
- `mst_addr` out 7, address to master, stable from `mst_start` until RESP
- `mst_data` out 8, data byte to master, stable likewise
- `mst_busy` in 1, master is in a transfer
- `mst_done` in 1, one-cycle end-of-transfer pulse
- `mst_nack` in 1, slave NACKed; sampled only with `mst_done`

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req` bit is high, choose the winner w as the first set bit searching from (last+1) mod NREQ upward with wrap.
  - Latch `req_addr`/`req_data` slice w into `mst_addr`/`mst_data`, set `gnt[w]`, clear retry count, go to ISSUE.
- ISSUE:
  - While `mst_busy`=1, stay.
  - Otherwise pulse `mst_start` for exactly one cycle, clear timer, go to WAIT.
- WAIT:
  - Timer increments every cycle.
  - On `mst_done` with `mst_nack`=0: result ACK, go to RESP.
  - On `mst_done` with `mst_nack`=1: see Configuration.
  - If timer reaches TIMEOUT_CYC-1 with no `mst_done`: result NACK, pulse `timeout`, go to RESP.
  - If `mst_done` and timer expiry occur in the same cycle, `mst_done` wins and no timeout is reported.
- RESP:
  - Pulse `done[w]`, drive `nack[w]` with the result.
  - Clear `gnt`, set last=w, go to IDLE.
- Requests and data changes:
  - Deassertion of `req[w]` during service is ignored; the transaction completes and `done` still pulses.
  - Changes on `req_addr`/`req_data` after latch are ignored.
- Reset:
  - Reset (`reset`=0) in any state forces IDLE and sets last=NREQ-1, so requester 0 has first priority.
  - All outputs are 0 during and after reset: `gnt`, `done`, `nack`, `timeout`, `busy`, `mst_start`, `mst_addr`, `mst_data`.
  - An in-flight transaction is dropped with no `done`.

## Timing
- `req` high in IDLE → `gnt` high at the next edge.
- `mst_start` rises one cycle after `gnt` if `mst_busy`=0.
- `mst_done` → `done`/`nack` pulse two edges later (WAIT→RESP, outputs registered in RESP).
- Minimum requester turnaround: 4 cycles plus master transfer time.
- A requester still holding `req` after `done` may be re-granted at the earliest 1 cycle after RESP, but only if no other requester is pending.
- `mst_start` is never asserted while `mst_busy`=1, and is never asserted twice per attempt.
- The timer width is ceil(log2(TIMEOUT_CYC)) bits, saturating; it is cleared on each retry.

## Configuration
- `I2C_ARB_RETRY_EN` defined:
  - On `mst_done` with `mst_nack`=1 and retry count < MAX_RETRY: increment the count and return to ISSUE with address/data unchanged.
  - Once the count reaches MAX_RETRY: result NACK, go to RESP.
  - Timeouts are not retried.
- Not defined: NACK goes directly to RESP with result NACK; no retry counter is synthesized.

## Test plan
- Single request: `req[2]`=1, addr 0x3F, data 0x41, master ACKs → `gnt`=0100 next cycle, one `mst_start` with 0x3F/0x41, `done[2]` pulse, `nack[2]`=0.
- Simultaneous requests on 0,1,3 after reset → served in order 0,1,3.
  - Then `req[0]` is re-asserted while 1 and 3 are pending → order 1,3,0.
- Busy master: `mst_busy`=1 for 10 cycles after grant → `mst_start` is delayed until the cycle `mst_busy` falls; exactly one pulse.
- NACK with `I2C_ARB_RETRY_EN`, MAX_RETRY=2, master always NACKs → 3 `mst_start` pulses, then `done` with `nack`=1.
  - Without the macro: 1 pulse, then `nack`=1.
- Timeout: master never returns `mst_done`, TIMEOUT_CYC=64 → `timeout` and `done[w]`/`nack[w]`=1 after 64 WAIT cycles.
  - Also: `mst_done` arriving exactly on expiry → `nack`=0 and no `timeout` pulse.
- Reset mid-WAIT: `reset`=0 for 1 cycle → all outputs 0, no `done`.
  - Pending `req[1]`,`req[3]` → `gnt[1]` first after release.
